// File: rtl/setassoc_cache_ctrl.sv
// setassoc_cache_ctrl: 1/2-way write-back, write-allocate cache
// shared by fetch and data ports, line-wide req/ack refill
module setassoc_cache_ctrl #(
   parameter int WORD_SIZE  = 16,
   parameter int SETS       = 4,
   parameter int LINE_WORDS = 4,
   parameter int WAYS       = 2,
   parameter int CNT_W      = 21
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            i_read,
   input  logic [WORD_SIZE-1:0]            i_addr,
   output logic [WORD_SIZE-1:0]            i_data,
   output logic                            i_stall,
   input  logic                            d_read,
   input  logic                            d_write,
   input  logic [WORD_SIZE-1:0]            d_addr,
   input  logic [WORD_SIZE-1:0]            d_wdata,
   output logic [WORD_SIZE-1:0]            d_rdata,
   output logic                            d_stall,
   output logic                            mem_req,
   output logic                            mem_we,
   output logic [WORD_SIZE-1:0]            mem_addr,
   output logic [WORD_SIZE*LINE_WORDS-1:0] mem_wdata,
   input  logic [WORD_SIZE*LINE_WORDS-1:0] mem_rdata,
   input  logic                            mem_ack,
   output logic [CNT_W-1:0]                access_cnt,
   output logic [CNT_W-1:0]                miss_cnt
);
   localparam int OFF_W  = $clog2(LINE_WORDS);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = WORD_SIZE - OFF_W - IDX_W;
   localparam int LINE_W = WORD_SIZE * LINE_WORDS;

   typedef enum logic [1:0] {IDLE, WB, FILL} state_t;
   state_t state;

   // way 1 storage exists in both builds; a 1-way build never allocates it
   logic              valid_q [SETS][2];
   logic              dirty_q [SETS][2];
   logic [TAG_W-1:0]  tag_q   [SETS][2];
   logic [LINE_W-1:0] data_q  [SETS][2];
   logic              lru_q   [SETS];

   logic [OFF_W-1:0] i_off, d_off;
   logic [IDX_W-1:0] i_idx, d_idx, m_idx, m_idx_n;
   logic [TAG_W-1:0] i_tag, d_tag, m_tag, m_tag_n;
   logic [1:0]       i_way_hit, d_way_hit;
   logic             i_match, d_match, i_way, d_way;
   logic             idle, i_hit, d_hit, d_req, i_done, d_done;
   logic             d_miss, i_miss, miss_start;
   logic             v_way, v_way_n, v_dirty_n, fill_en;
   logic [LINE_W-1:0] i_line, d_line;

   assign {i_tag, i_idx, i_off} = i_addr;
   assign {d_tag, d_idx, d_off} = d_addr;

   // tag compare of both ways for both ports
   always_comb begin
      i_way_hit = '0;
      d_way_hit = '0;
      for (int w = 0; w < 2; w++) begin
         i_way_hit[w] = valid_q[i_idx][w] && (tag_q[i_idx][w] == i_tag);
         d_way_hit[w] = valid_q[d_idx][w] && (tag_q[d_idx][w] == d_tag);
      end
   end

   assign i_match = |i_way_hit;
   assign d_match = |d_way_hit;
   assign i_way   = i_way_hit[1];
   assign d_way   = d_way_hit[1];
   assign i_line  = data_q[i_idx][i_way];
   assign d_line  = data_q[d_idx][d_way];
   assign i_data  = i_line[i_off*WORD_SIZE +: WORD_SIZE];
   assign d_rdata = d_line[d_off*WORD_SIZE +: WORD_SIZE];

   assign idle    = (state == IDLE);
   assign d_req   = d_read || d_write;
   assign i_hit   = idle && i_match;
   assign d_hit   = idle && d_match;
   assign d_stall = d_req && !d_hit;
   assign i_stall = i_read && (!i_hit || d_stall);
   assign i_done  = i_read && !i_stall;
   assign d_done  = d_req && !d_stall;

   // a completing data hit goes first so the victim snapshot sees its write
   assign d_miss     = idle && d_req && !d_match;
   assign i_miss     = idle && i_read && !i_match && !d_req;
   assign miss_start = d_miss || i_miss;
   assign m_tag_n    = d_miss ? d_tag : i_tag;
   assign m_idx_n    = d_miss ? d_idx : i_idx;
   assign fill_en    = (state == FILL) && mem_ack;

   // victim: first invalid way, else the LRU way
   always_comb begin
      v_way_n = 1'b0;
      if (valid_q[m_idx_n][0] && WAYS == 2)
         v_way_n = valid_q[m_idx_n][1] ? lru_q[m_idx_n] : 1'b1;
      v_dirty_n = valid_q[m_idx_n][v_way_n] && dirty_q[m_idx_n][v_way_n];
   end

   // miss FSM with registered memory interface
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         m_tag     <= '0;
         m_idx     <= '0;
         v_way     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (miss_start) begin
               m_tag   <= m_tag_n;
               m_idx   <= m_idx_n;
               v_way   <= v_way_n;
               mem_req <= 1'b1;
               if (v_dirty_n) begin
                  state     <= WB;
                  mem_we    <= 1'b1;
                  mem_addr  <= {tag_q[m_idx_n][v_way_n], m_idx_n, {OFF_W{1'b0}}};
                  mem_wdata <= data_q[m_idx_n][v_way_n];
               end else begin
                  state    <= FILL;
                  mem_we   <= 1'b0;
                  mem_addr <= {m_tag_n, m_idx_n, {OFF_W{1'b0}}};
               end
            end
            WB: if (mem_ack) begin
               state    <= FILL;
               mem_we   <= 1'b0;
               mem_addr <= {m_tag, m_idx, {OFF_W{1'b0}}};
            end
            FILL: if (mem_ack) begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // valid, dirty and LRU bookkeeping; data port wins the LRU on a shared set
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < SETS; s++) begin
            lru_q[s] <= 1'b0;
            for (int w = 0; w < 2; w++) begin
               valid_q[s][w] <= 1'b0;
               dirty_q[s][w] <= 1'b0;
            end
         end
      end else begin
         if (fill_en) begin
            valid_q[m_idx][v_way] <= 1'b1;
            dirty_q[m_idx][v_way] <= 1'b0;
            lru_q[m_idx]          <= ~v_way;
         end
         if (i_done)
            lru_q[i_idx] <= ~i_way;
         if (d_done) begin
            lru_q[d_idx] <= ~d_way;
            if (d_write)
               dirty_q[d_idx][d_way] <= 1'b1;
         end
      end
   end

   // tag and line storage: refill and write hits
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_q[m_idx][v_way]  <= m_tag;
         data_q[m_idx][v_way] <= mem_rdata;
      end
      if (d_done && d_write)
         data_q[d_idx][d_way][d_off*WORD_SIZE +: WORD_SIZE] <= d_wdata;
   end

   logic [CNT_W:0] acc_sum;
   assign acc_sum = {1'b0, access_cnt} + {{CNT_W{1'b0}}, i_done}
                  + {{CNT_W{1'b0}}, d_done};

   // saturating performance counters
   always_ff @(posedge clk) begin
      if (reset) begin
         access_cnt <= '0;
         miss_cnt   <= '0;
      end else begin
         access_cnt <= acc_sum[CNT_W] ? '1 : acc_sum[CNT_W-1:0];
         if (miss_start && miss_cnt != '1)
            miss_cnt <= miss_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_setassoc_cache_ctrl.sv
// tb_setassoc_cache_ctrl: scoreboard bench for the default 2-way
// build and a 1-way / 8-set / 2-word build
module tb_setassoc_cache_ctrl;
   localparam int LAT   = 5;
   localparam int LAT_B = 3;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [63:0] wdata;
   } mreq_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   logic        i_read, i_stall, d_read, d_write, d_stall;
   logic [15:0] i_addr, i_data, d_addr, d_wdata, d_rdata;
   logic        mem_req, mem_we, mem_ack, model_ack, extra_ack;
   logic [15:0] mem_addr;
   logic [63:0] mem_wdata, mem_rdata;
   logic [20:0] access_cnt, miss_cnt;
   assign mem_ack = model_ack | extra_ack;

   logic        b_i_read, b_i_stall, b_d_read, b_d_write, b_d_stall;
   logic [15:0] b_i_addr, b_i_data, b_d_addr, b_d_wdata, b_d_rdata;
   logic        b_mem_req, b_mem_we, b_mem_ack;
   logic [15:0] b_mem_addr;
   logic [31:0] b_mem_wdata, b_mem_rdata;
   logic [20:0] b_access_cnt, b_miss_cnt;

   setassoc_cache_ctrl dut (
      .clk(clk), .reset(reset),
      .i_read(i_read), .i_addr(i_addr), .i_data(i_data), .i_stall(i_stall),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_stall(d_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .access_cnt(access_cnt), .miss_cnt(miss_cnt)
   );

   setassoc_cache_ctrl #(.SETS(8), .LINE_WORDS(2), .WAYS(1)) dut_b (
      .clk(clk), .reset(reset),
      .i_read(b_i_read), .i_addr(b_i_addr), .i_data(b_i_data),
      .i_stall(b_i_stall),
      .d_read(b_d_read), .d_write(b_d_write), .d_addr(b_d_addr),
      .d_wdata(b_d_wdata), .d_rdata(b_d_rdata), .d_stall(b_d_stall),
      .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack),
      .access_cnt(b_access_cnt), .miss_cnt(b_miss_cnt)
   );

   mreq_t       exp_a[$], exp_b[$];
   logic [15:0] exp_i[$], exp_d[$], exp_bd[$];
   logic [15:0] bmem_a [256];
   logic [15:0] ref_a  [256];
   logic [15:0] bmem_b [256];
   logic [15:0] ref_b  [256];
   int n_tests = 0;
   int n_fail  = 0;
   int exp_acc = 0;
   int exp_miss = 0;

   // memory model for the 2-way build; checks each request on its ack
   initial begin : mem_model_a
      int cnt;
      bit stable;
      logic [15:0] a0;
      logic we0;
      logic [63:0] wd0;
      mreq_t e;
      cnt = 0; stable = 1'b1; a0 = '0; we0 = 1'b0; wd0 = '0;
      model_ack = 1'b0; mem_rdata = '0;
      forever begin
         @(negedge clk);
         model_ack = 1'b0;
         if (mem_req === 1'b1) begin
            if (cnt == 0) begin
               a0 = mem_addr; we0 = mem_we; wd0 = mem_wdata; stable = 1'b1;
            end else if (mem_addr !== a0 || mem_we !== we0 || mem_wdata !== wd0)
               stable = 1'b0;
            cnt++;
            if (cnt == LAT) begin
               cnt = 0;
               model_ack = 1'b1;
               n_tests++;
               if (exp_a.size() == 0) begin
                  n_fail++;
                  $display("FAIL mem_a_unexpected: got we=%0b addr=%h, required no request",
                           mem_we, mem_addr);
               end else begin
                  e = exp_a.pop_front();
                  if (mem_we !== e.we || mem_addr !== e.addr ||
                      (e.we && mem_wdata !== e.wdata)) begin
                     n_fail++;
                     $display("FAIL mem_a_req: got we=%0b addr=%h wd=%h, required we=%0b addr=%h wd=%h",
                              mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
                  end
               end
               n_tests++;
               if (!stable) begin
                  n_fail++;
                  $display("FAIL mem_a_stable: got changing request, required stable from %h", a0);
               end
               for (int k = 0; k < 4; k++) begin
                  if (mem_we) bmem_a[int'(mem_addr[7:0]) + k] = mem_wdata[k*16 +: 16];
                  else mem_rdata[k*16 +: 16] = bmem_a[int'(mem_addr[7:0]) + k];
               end
            end
         end else
            cnt = 0;
      end
   end

   // memory model for the 1-way build
   initial begin : mem_model_b
      int cnt;
      mreq_t e;
      cnt = 0; b_mem_ack = 1'b0; b_mem_rdata = '0;
      forever begin
         @(negedge clk);
         b_mem_ack = 1'b0;
         if (b_mem_req === 1'b1) begin
            cnt++;
            if (cnt == LAT_B) begin
               cnt = 0;
               b_mem_ack = 1'b1;
               n_tests++;
               if (exp_b.size() == 0) begin
                  n_fail++;
                  $display("FAIL mem_b_unexpected: got we=%0b addr=%h, required no request",
                           b_mem_we, b_mem_addr);
               end else begin
                  e = exp_b.pop_front();
                  if (b_mem_we !== e.we || b_mem_addr !== e.addr ||
                      (e.we && {32'h0, b_mem_wdata} !== e.wdata)) begin
                     n_fail++;
                     $display("FAIL mem_b_req: got we=%0b addr=%h wd=%h, required we=%0b addr=%h wd=%h",
                              b_mem_we, b_mem_addr, b_mem_wdata, e.we, e.addr, e.wdata);
                  end
               end
               for (int k = 0; k < 2; k++) begin
                  if (b_mem_we) bmem_b[int'(b_mem_addr[7:0]) + k] = b_mem_wdata[k*16 +: 16];
                  else b_mem_rdata[k*16 +: 16] = bmem_b[int'(b_mem_addr[7:0]) + k];
               end
            end
         end else
            cnt = 0;
      end
   end

   task automatic access_a(input bit rd_i, input logic [15:0] ia,
                           input bit rd_d, input bit wr_d,
                           input logic [15:0] da, input logic [15:0] wd,
                           output bit stall0, output int i_cyc, output int d_cyc);
      bit ip, dp;
      int n;
      logic [15:0] e;
      ip = rd_i; dp = rd_d | wr_d; n = 0;
      i_cyc = -1; d_cyc = -1; stall0 = 1'b0;
      if (rd_i) exp_i.push_back(ref_a[ia[7:0]]);
      if (rd_d) exp_d.push_back(ref_a[da[7:0]]);
      if (wr_d) ref_a[da[7:0]] = wd;
      while ((ip || dp) && n < 100) begin
         @(posedge clk); #1;
         i_read = ip; i_addr = ia;
         d_read = dp && rd_d; d_write = dp && wr_d;
         d_addr = da; d_wdata = wd;
         @(negedge clk);
         if (n == 0) stall0 = (rd_i && i_stall) || ((rd_d || wr_d) && d_stall);
         if (ip && !i_stall) begin
            ip = 1'b0; i_cyc = n;
            e = exp_i.pop_front();
            n_tests++;
            if (i_data !== e) begin
               n_fail++;
               $display("FAIL i_data @%h: got %h, required %h", ia, i_data, e);
            end
         end
         if (dp && !d_stall) begin
            dp = 1'b0; d_cyc = n;
            if (rd_d) begin
               e = exp_d.pop_front();
               n_tests++;
               if (d_rdata !== e) begin
                  n_fail++;
                  $display("FAIL d_rdata @%h: got %h, required %h", da, d_rdata, e);
               end
            end
         end
         n++;
      end
      if (ip || dp) begin
         n_tests++; n_fail++;
         $display("FAIL access_timeout: got pending i=%0b d=%0b, required done", ip, dp);
         exp_i.delete(); exp_d.delete();
      end
      @(posedge clk); #1;
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
   endtask

   task automatic access_b(input bit wr, input logic [15:0] da,
                           input logic [15:0] wd, output bit stall0);
      bit dp;
      int n;
      logic [15:0] e;
      dp = 1'b1; n = 0; stall0 = 1'b0;
      if (!wr) exp_bd.push_back(ref_b[da[7:0]]);
      else ref_b[da[7:0]] = wd;
      while (dp && n < 100) begin
         @(posedge clk); #1;
         b_d_read = !wr; b_d_write = wr; b_d_addr = da; b_d_wdata = wd;
         @(negedge clk);
         if (n == 0) stall0 = b_d_stall;
         if (!b_d_stall) begin
            dp = 1'b0;
            if (!wr) begin
               e = exp_bd.pop_front();
               n_tests++;
               if (b_d_rdata !== e) begin
                  n_fail++;
                  $display("FAIL b_d_rdata @%h: got %h, required %h", da, b_d_rdata, e);
               end
            end
         end
         n++;
      end
      if (dp) begin
         n_tests++; n_fail++;
         $display("FAIL b_access_timeout: got pending, required done");
         exp_bd.delete();
      end
      @(posedge clk); #1;
      b_d_read = 1'b0; b_d_write = 1'b0;
   endtask

   task automatic check_counters(input string tag);
      n_tests++;
      if (access_cnt !== 21'(exp_acc) || miss_cnt !== 21'(exp_miss)) begin
         n_fail++;
         $display("FAIL %s counters: got acc=%0d miss=%0d, required acc=%0d miss=%0d",
                  tag, access_cnt, miss_cnt, exp_acc, exp_miss);
      end
      n_tests++;
      if (exp_a.size() != 0) begin
         n_fail++;
         $display("FAIL %s mem_pending: got %0d outstanding, required 0", tag, exp_a.size());
         exp_a.delete();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      n_tests++;
      if (mem_req !== 1'b0 || mem_we !== 1'b0 || b_mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mem: got req=%0b we=%0b breq=%0b, required 0 0 0",
                  mem_req, mem_we, b_mem_req);
      end
      n_tests++;
      if (i_stall !== 1'b0 || d_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_stall: got i=%0b d=%0b, required 0 0", i_stall, d_stall);
      end
      n_tests++;
      if (b_access_cnt !== 21'd0 || b_miss_cnt !== 21'd0) begin
         n_fail++;
         $display("FAIL reset_b_cnt: got %0d %0d, required 0 0", b_access_cnt, b_miss_cnt);
      end
      check_counters("reset");
   endtask

   task automatic test_cold_fetch();
      bit s0;
      int ic, dc;
      exp_a.push_back('{we: 1'b0, addr: 16'h0020, wdata: 64'h0});
      access_a(1'b1, 16'h0023, 1'b0, 1'b0, 16'h0, 16'h0, s0, ic, dc);
      exp_acc++; exp_miss++;
      n_tests++;
      if (s0 !== 1'b1 || ic != LAT + 1) begin
         n_fail++;
         $display("FAIL cold_fetch_timing: got stall0=%0b done@%0d, required 1 @%0d",
                  s0, ic, LAT + 1);
      end
      check_counters("cold_fetch");
   endtask

   task automatic test_write_allocate();
      bit s0;
      int ic, dc;
      exp_a.push_back('{we: 1'b0, addr: 16'h0040, wdata: 64'h0});
      access_a(1'b0, 16'h0, 1'b0, 1'b1, 16'h0041, 16'hBEEF, s0, ic, dc);
      exp_acc++; exp_miss++;
      n_tests++;
      if (s0 !== 1'b1 || dc != LAT + 1) begin
         n_fail++;
         $display("FAIL wmiss_timing: got stall0=%0b done@%0d, required 1 @%0d",
                  s0, dc, LAT + 1);
      end
      access_a(1'b0, 16'h0, 1'b1, 1'b0, 16'h0041, 16'h0, s0, ic, dc);
      exp_acc++;
      n_tests++;
      if (s0 !== 1'b0 || dc != 0) begin
         n_fail++;
         $display("FAIL rd_after_wr: got stall0=%0b done@%0d, required 0 @0", s0, dc);
      end
      check_counters("write_allocate");
   endtask

   task automatic test_same_word();
      bit s0;
      int ic, dc;
      access_a(1'b1, 16'h0042, 1'b0, 1'b1, 16'h0042, 16'h1234, s0, ic, dc);
      exp_acc += 2;
      n_tests++;
      if (s0 !== 1'b0 || ic != 0 || dc != 0) begin
         n_fail++;
         $display("FAIL same_word_timing: got stall0=%0b i@%0d d@%0d, required 0 @0 @0",
                  s0, ic, dc);
      end
      access_a(1'b0, 16'h0, 1'b1, 1'b0, 16'h0042, 16'h0, s0, ic, dc);
      exp_acc++;
      check_counters("same_word");
   endtask

   task automatic test_back_to_back();
      logic [15:0] e;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         i_read = 1'b1; i_addr = 16'h0020 + 16'(k);
         d_read = 1'b1; d_addr = 16'h0040 + 16'(k);
         exp_i.push_back(ref_a[8'h20 + 8'(k)]);
         exp_d.push_back(ref_a[8'h40 + 8'(k)]);
         @(negedge clk);
         n_tests++;
         if (i_stall !== 1'b0 || d_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_stall %0d: got i=%0b d=%0b, required 0 0", k, i_stall, d_stall);
         end
         e = exp_i.pop_front();
         n_tests++;
         if (i_data !== e) begin
            n_fail++;
            $display("FAIL b2b_i_data %0d: got %h, required %h", k, i_data, e);
         end
         e = exp_d.pop_front();
         n_tests++;
         if (d_rdata !== e) begin
            n_fail++;
            $display("FAIL b2b_d_data %0d: got %h, required %h", k, d_rdata, e);
         end
      end
      @(posedge clk); #1;
      i_read = 1'b0; d_read = 1'b0;
      exp_acc += 8;
      check_counters("back_to_back");
   endtask

   task automatic test_lru_victim();
      bit s0;
      int ic, dc;
      logic [63:0] vl;
      exp_a.push_back('{we: 1'b0, addr: 16'h0000, wdata: 64'h0});
      access_a(1'b0, 16'h0, 1'b1, 1'b0, 16'h0000, 16'h0, s0, ic, dc);
      access_a(1'b0, 16'h0, 1'b1, 1'b0, 16'h0041, 16'h0, s0, ic, dc);
      n_tests++;
      if (s0 !== 1'b0) begin
         n_fail++;
         $display("FAIL lru_hit_0041: got stall0=%0b, required 0", s0);
      end
      exp_a.push_back('{we: 1'b0, addr: 16'h0080, wdata: 64'h0});
      access_a(1'b0, 16'h0, 1'b1, 1'b0, 16'h0080, 16'h0, s0, ic, dc);
      vl = {ref_a[8'h43], ref_a[8'h42], ref_a[8'h41], ref_a[8'h40]};
      exp_a.push_back('{we: 1'b1, addr: 16'h0040, wdata: vl});
      exp_a.push_back('{we: 1'b0, addr: 16'h0000, wdata: 64'h0});
      access_a(1'b0, 16'h0, 1'b1, 1'b0, 16'h0000, 16'h0, s0, ic, dc);
      n_tests++;
      if (dc != 2 * LAT + 1) begin
         n_fail++;
         $display("FAIL wb_fill_timing: got done@%0d, required @%0d", dc, 2 * LAT + 1);
      end
      exp_acc += 4; exp_miss += 3;
      check_counters("lru_victim");
   endtask

   task automatic test_shared_fill();
      bit s0;
      int ic, dc;
      exp_a.push_back('{we: 1'b0, addr: 16'h0030, wdata: 64'h0});
      access_a(1'b1, 16'h0031, 1'b1, 1'b0, 16'h0032, 16'h0, s0, ic, dc);
      exp_acc += 2; exp_miss++;
      n_tests++;
      if (ic != LAT + 1 || dc != LAT + 1) begin
         n_fail++;
         $display("FAIL shared_fill_timing: got i@%0d d@%0d, required both @%0d",
                  ic, dc, LAT + 1);
      end
      check_counters("shared_fill");
   endtask

   task automatic test_reset_mid_fill();
      bit s0;
      int ic, dc, n;
      @(posedge clk); #1;
      d_read = 1'b1; d_addr = 16'h0050;
      n = 0;
      @(negedge clk);
      while (mem_req !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      n_tests++;
      if (mem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_fill_req: got req=%0b, required 1", mem_req);
      end
      @(posedge clk); #1;
      reset = 1'b1; d_read = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0; extra_ack = 1'b1;
      @(negedge clk);
      n_tests++;
      if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_fill_drop: got req=%0b we=%0b, required 0 0", mem_req, mem_we);
      end
      @(posedge clk); #1;
      extra_ack = 1'b0;
      @(negedge clk);
      n_tests++;
      if (mem_req !== 1'b0 || i_stall !== 1'b0 || d_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_stray_ack: got req=%0b istall=%0b dstall=%0b, required 0 0 0",
                  mem_req, i_stall, d_stall);
      end
      exp_acc = 0; exp_miss = 0;
      check_counters("reset_mid_fill");
      for (int a = 0; a < 256; a++) ref_a[a] = bmem_a[a];
      exp_a.push_back('{we: 1'b0, addr: 16'h0040, wdata: 64'h0});
      access_a(1'b0, 16'h0, 1'b1, 1'b0, 16'h0041, 16'h0, s0, ic, dc);
      exp_acc++; exp_miss++;
      n_tests++;
      if (s0 !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_remiss: got stall0=%0b, required 1", s0);
      end
      check_counters("reset_refill");
   endtask

   task automatic test_one_way();
      bit s0;
      exp_b.push_back('{we: 1'b0, addr: 16'h0002, wdata: 64'h0});
      access_b(1'b1, 16'h0002, 16'hCAFE, s0);
      n_tests++;
      if (s0 !== 1'b1) begin
         n_fail++;
         $display("FAIL b_wmiss: got stall0=%0b, required 1", s0);
      end
      exp_b.push_back('{we: 1'b1, addr: 16'h0002,
                        wdata: {32'h0, ref_b[8'h03], ref_b[8'h02]}});
      exp_b.push_back('{we: 1'b0, addr: 16'h0012, wdata: 64'h0});
      access_b(1'b0, 16'h0012, 16'h0, s0);
      n_tests++;
      if (b_miss_cnt !== 21'd2 || b_access_cnt !== 21'd2) begin
         n_fail++;
         $display("FAIL b_counters: got miss=%0d acc=%0d, required 2 2",
                  b_miss_cnt, b_access_cnt);
      end
      exp_b.push_back('{we: 1'b0, addr: 16'h0002, wdata: 64'h0});
      access_b(1'b0, 16'h0002, 16'h0, s0);
      n_tests++;
      if (exp_b.size() != 0 || b_miss_cnt !== 21'd3) begin
         n_fail++;
         $display("FAIL b_pending: got %0d outstanding miss=%0d, required 0 3",
                  exp_b.size(), b_miss_cnt);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, required finish by 400000");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; extra_ack = 1'b0;
      i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
      d_addr = '0; d_wdata = '0;
      b_i_read = 1'b0; b_i_addr = '0; b_d_read = 1'b0; b_d_write = 1'b0;
      b_d_addr = '0; b_d_wdata = '0;
      for (int a = 0; a < 256; a++) begin
         bmem_a[a] = 16'(a) ^ 16'h5A5A;
         bmem_b[a] = 16'(a) ^ 16'hC3C3;
      end
      bmem_a[8'h23] = 16'h6000;
      for (int a = 0; a < 256; a++) begin
         ref_a[a] = bmem_a[a];
         ref_b[a] = bmem_b[a];
      end
      test_reset();
      test_cold_fetch();
      test_write_allocate();
      test_same_word();
      test_back_to_back();
      test_lru_victim();
      test_shared_fill();
      test_reset_mid_fill();
      test_one_way();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
